// File: rtl/apb_master_arb_if.sv
// Bundles the requester handshake and APB bus signals of apb_master_arb.
// The master modport is the arbiter view; the slave modport is the requester/APB-slave side.
interface apb_master_arb_if #(
   parameter int ADDRESSWIDTH = 3,
   parameter int DATAWIDTH    = 16
);
   logic                    req0_i;
   logic                    req0_write_i;
   logic [ADDRESSWIDTH-1:0] req0_addr_i;
   logic [DATAWIDTH-1:0]    req0_wdata_i;
   logic                    req1_i;
   logic                    req1_write_i;
   logic [ADDRESSWIDTH-1:0] req1_addr_i;
   logic [DATAWIDTH-1:0]    req1_wdata_i;
   logic                    done0_o;
   logic                    done1_o;
   logic [DATAWIDTH-1:0]    rdata_o;
   logic                    err_o;
   logic                    busy_o;
   logic                    PSELx_o;
   logic                    PENABLE_o;
   logic                    PWRITE_o;
   logic [ADDRESSWIDTH-1:0] PADDR_o;
   logic [DATAWIDTH-1:0]    PWDATA_o;
   logic [DATAWIDTH-1:0]    PRDATA_i;
   logic                    PREADY_i;

   modport master (
      input  req0_i, req0_write_i, req0_addr_i, req0_wdata_i,
      input  req1_i, req1_write_i, req1_addr_i, req1_wdata_i,
      input  PRDATA_i, PREADY_i,
      output done0_o, done1_o, rdata_o, err_o, busy_o,
      output PSELx_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o
   );

   modport slave (
      output req0_i, req0_write_i, req0_addr_i, req0_wdata_i,
      output req1_i, req1_write_i, req1_addr_i, req1_wdata_i,
      output PRDATA_i, PREADY_i,
      input  done0_o, done1_o, rdata_o, err_o, busy_o,
      input  PSELx_o, PENABLE_o, PWRITE_o, PADDR_o, PWDATA_o
   );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master with registered outputs and PREADY wait states.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles and flag it on err_o.
module apb_master_arb #(
   parameter int ADDRESSWIDTH = 3,
   parameter int DATAWIDTH    = 16,
   parameter int TIMEOUT      = 16
) (
   input logic              PCLK,
   input logic              PRESETn,
   apb_master_arb_if.master bus
);
   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
      $error("apb_master_arb: TIMEOUT must be in 2..255");
   end

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, CAPTURE} state_e;

   state_e                  state_q, state_d;
   logic                    last_grant_q, last_grant_d;
   logic                    grant_q, grant_d;
   logic                    psel_q, psel_d;
   logic                    penable_q, penable_d;
   logic                    pwrite_q, pwrite_d;
   logic [ADDRESSWIDTH-1:0] paddr_q, paddr_d;
   logic [DATAWIDTH-1:0]    pwdata_q, pwdata_d;
   logic [DATAWIDTH-1:0]    rdata_q, rdata_d;
   logic                    done0_q, done0_d;
   logic                    done1_q, done1_d;
   logic                    err_q, err_d;
   logic                    busy_q, busy_d;
   logic                    elig0, elig1;
   logic                    timed_out;

`ifdef APB_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       tmo_q, tmo_d;
   assign timed_out = tmo_q;
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      rdata_d      = rdata_q;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      err_d        = 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_d   = wait_cnt_q;
      tmo_d        = tmo_q;
`endif
      // A requester in its done cycle still holds req; masking it prevents a repeat transfer.
      elig0 = bus.req0_i & ~done0_q;
      elig1 = bus.req1_i & ~done1_q;
      unique case (state_q)
         IDLE: begin
            if (elig0 | elig1) begin
               grant_d      = (elig0 & elig1) ? ~last_grant_q : elig1;
               last_grant_d = grant_d;
               pwrite_d     = grant_d ? bus.req1_write_i : bus.req0_write_i;
               paddr_d      = grant_d ? bus.req1_addr_i  : bus.req0_addr_i;
               pwdata_d     = grant_d ? bus.req1_wdata_i : bus.req0_wdata_i;
               psel_d       = 1'b1;
               state_d      = SETUP;
`ifdef APB_TIMEOUT_EN
               tmo_d        = 1'b0;
`endif
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end
         ACCESS: begin
            if (bus.PREADY_i) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = CAPTURE;
            end
`ifdef APB_TIMEOUT_EN
            else if (wait_cnt_q == TMO_LAST) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               tmo_d     = 1'b1;
               state_d   = CAPTURE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
`endif
         end
         CAPTURE: begin
            if (!pwrite_q && !timed_out) rdata_d = bus.PRDATA_i;
            done0_d = ~grant_q;
            done1_d = grant_q;
            err_d   = timed_out;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         rdata_q      <= '0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt_q   <= '0;
         tmo_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         rdata_q      <= rdata_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
`ifdef APB_TIMEOUT_EN
         wait_cnt_q   <= wait_cnt_d;
         tmo_q        <= tmo_d;
`endif
      end
   end

   assign bus.PSELx_o   = psel_q;
   assign bus.PENABLE_o = penable_q;
   assign bus.PWRITE_o  = pwrite_q;
   assign bus.PADDR_o   = paddr_q;
   assign bus.PWDATA_o  = pwdata_q;
   assign bus.rdata_o   = rdata_q;
   assign bus.done0_o   = done0_q;
   assign bus.done1_o   = done1_q;
   assign bus.err_o     = err_q;
   assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_apb_master_arb.sv
// Randomized scoreboard bench for apb_master_arb: requesters queue transfers, a monitor
// predicts grant order, APB timing and read data from a register-file model.
module tb_apb_master_arb;
   localparam int AW = 3;
   localparam int DW = 16;
   localparam int TB_TIMEOUT = 4;

   typedef struct packed {
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } txn_t;

   logic PCLK = 1'b0;
   logic PRESETn;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   apb_master_arb_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) bus ();
   apb_master_arb #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TB_TIMEOUT)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus)
   );

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   txn_t          q0[$];
   txn_t          q1[$];
   logic [DW-1:0] ref_mem [8];
   logic [DW-1:0] smem [8];
   int            force_waits = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_psel"},    32'(bus.PSELx_o),   32'(0));
      chk({tag, "_penable"}, 32'(bus.PENABLE_o), 32'(0));
      chk({tag, "_pwrite"},  32'(bus.PWRITE_o),  32'(0));
      chk({tag, "_paddr"},   32'(bus.PADDR_o),   32'(0));
      chk({tag, "_pwdata"},  32'(bus.PWDATA_o),  32'(0));
      chk({tag, "_rdata"},   32'(bus.rdata_o),   32'(0));
      chk({tag, "_done0"},   32'(bus.done0_o),   32'(0));
      chk({tag, "_done1"},   32'(bus.done1_o),   32'(0));
      chk({tag, "_err"},     32'(bus.err_o),     32'(0));
      chk({tag, "_busy"},    32'(bus.busy_o),    32'(0));
   endtask

   // Requester: queue the expected transfer, hold req until own done, then drop it.
   task automatic issue(input logic n, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, output int lat);
      txn_t t;
      int   t0;
      bit   got;
      t.w = w; t.a = a; t.d = d;
      @(posedge PCLK); #1;
      if (n == 1'b0) begin
         q0.push_back(t);
         bus.req0_i = 1'b1; bus.req0_write_i = w; bus.req0_addr_i = a; bus.req0_wdata_i = d;
      end else begin
         q1.push_back(t);
         bus.req1_i = 1'b1; bus.req1_write_i = w; bus.req1_addr_i = a; bus.req1_wdata_i = d;
      end
      t0 = cyc; got = 1'b0; lat = -1;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge PCLK);
         if ((n == 1'b0) ? bus.done0_o : bus.done1_o) begin
            got = 1'b1;
            lat = cyc - t0;
         end
      end
      if (!got) begin
         vectors++; miscompares++;
         $display("FAIL done_wait req%0d: got no done expected done within 300 cycles", n);
      end
      @(posedge PCLK); #1;
      if (n == 1'b0) bus.req0_i = 1'b0; else bus.req1_i = 1'b0;
   endtask

   task automatic agent(input logic n, input int count);
      int lat;
      repeat (count) begin
         repeat ($urandom_range(0, 3)) @(posedge PCLK);
         issue(n, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom), lat);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge PCLK); #1;
      PRESETn = 1'b0;
      #1 check_all_zero(tag);
      @(negedge PCLK);
      @(posedge PCLK); #1;
      PRESETn = 1'b1;
   endtask

   // APB slave: register file, random wait states, read data valid the cycle after completion.
   int            wleft;
   bit            pend;
   logic [AW-1:0] pa;
   logic          pw;
   logic [DW-1:0] pd;
   initial begin
      bus.PREADY_i = 1'b0; bus.PRDATA_i = '0; wleft = 0; pend = 1'b0;
      forever begin
         @(posedge PCLK); #2;
         if (!PRESETn) begin
            wleft = 0; pend = 1'b0; bus.PREADY_i = 1'b0;
         end else begin
            if (pend) begin
               if (pw) smem[pa] = pd; else bus.PRDATA_i = smem[pa];
               pend = 1'b0;
            end else begin
               bus.PRDATA_i = DW'($urandom);
            end
            if (bus.PSELx_o && !bus.PENABLE_o) begin
               wleft = (force_waits < 0) ? int'($urandom_range(0, 3)) : force_waits;
               bus.PREADY_i = 1'($urandom_range(0, 1));
            end else if (bus.PSELx_o && bus.PENABLE_o) begin
               if (wleft > 0) begin
                  bus.PREADY_i = 1'b0; wleft--;
               end else begin
                  bus.PREADY_i = 1'b1; pend = 1'b1;
                  pa = bus.PADDR_o; pw = bus.PWRITE_o; pd = bus.PWDATA_o;
               end
            end else begin
               bus.PREADY_i = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   // Monitor: one open transfer at a time; round-robin choice among pending requesters.
   bit            exp_setup = 1'b0;
   logic          pred = 1'b0;
   logic          last_served = 1'b1;
   bit            in_xfer = 1'b0;
   txn_t          act;
   logic          act_req;
   int            s_cyc, comp_cyc, lows;
   bit            act_to;
   logic [DW-1:0] act_rd;
   logic [DW-1:0] exp_rdata = '0;
   bit            e_psel, e_pen, e_busy, e_err, closing, el0, el1;
   logic [1:0]    e_done;

   always @(negedge PCLK) begin
      if (!PRESETn) begin
         if (in_xfer) begin
            if (act_req == 1'b0) q0.push_front(act); else q1.push_front(act);
            in_xfer = 1'b0;
         end
         exp_setup = 1'b0; last_served = 1'b1; exp_rdata = '0;
      end else begin
         e_psel = 0; e_pen = 0; e_busy = 0; e_err = 0; e_done = '0; closing = 0;
         chk("grant_start", 32'(bus.PSELx_o && !bus.PENABLE_o), 32'(exp_setup));
         if (exp_setup) begin
            if ((pred == 1'b0) ? (q0.size() == 0) : (q1.size() == 0)) begin
               vectors++; miscompares++;
               $display("FAIL grant_queue: got grant to req%0d expected a queued transfer", pred);
            end else begin
               act = (pred == 1'b0) ? q0.pop_front() : q1.pop_front();
               act_req = pred; last_served = pred; in_xfer = 1'b1;
               s_cyc = cyc; comp_cyc = -1; lows = 0; act_to = 1'b0;
            end
         end
         if (in_xfer) begin
            if (cyc == s_cyc) begin
               e_psel = 1; e_busy = 1;
            end else if (comp_cyc < 0) begin
               e_psel = 1; e_pen = 1; e_busy = 1;
               if (bus.PREADY_i) begin
                  comp_cyc = cyc;
                  if (act.w) ref_mem[act.a] = act.d; else act_rd = ref_mem[act.a];
               end
`ifdef APB_TIMEOUT_EN
               else begin
                  lows++;
                  if (lows == TB_TIMEOUT) begin comp_cyc = cyc; act_to = 1'b1; end
               end
`endif
            end else if (cyc == comp_cyc + 1) begin
               e_busy = 1;
            end else begin
               e_done[act_req] = 1'b1; e_err = act_to;
               if (!act.w && !act_to) exp_rdata = act_rd;
               in_xfer = 1'b0; closing = 1'b1;
            end
            if (e_psel) begin
               chk("paddr", 32'(bus.PADDR_o), 32'(act.a));
               chk("pwrite", 32'(bus.PWRITE_o), 32'(act.w));
               if (act.w) chk("pwdata", 32'(bus.PWDATA_o), 32'(act.d));
            end
         end
         chk("psel", 32'(bus.PSELx_o), 32'(e_psel));
         chk("penable", 32'(bus.PENABLE_o), 32'(e_pen));
         chk("busy", 32'(bus.busy_o), 32'(e_busy));
         chk("done0", 32'(bus.done0_o), 32'(e_done[0]));
         chk("done1", 32'(bus.done1_o), 32'(e_done[1]));
         chk("err", 32'(bus.err_o), 32'(e_err));
         chk("rdata", 32'(bus.rdata_o), 32'(exp_rdata));
         if (!in_xfer) begin
            el0 = bus.req0_i && !(closing && act_req == 1'b0);
            el1 = bus.req1_i && !(closing && act_req == 1'b1);
            exp_setup = el0 || el1;
            pred = (el0 && el1) ? ~last_served : el1;
         end else begin
            exp_setup = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion expected finish within 100000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  lat;
      int  lat_r;
      bit  got;
      PRESETn = 1'b0;
      bus.req0_i = 1'b0; bus.req0_write_i = 1'b0; bus.req0_addr_i = '0; bus.req0_wdata_i = '0;
      bus.req1_i = 1'b0; bus.req1_write_i = 1'b0; bus.req1_addr_i = '0; bus.req1_wdata_i = '0;
      for (int i = 0; i < 8; i++) begin
         ref_mem[i] = DW'($urandom);
         smem[i] = ref_mem[i];
      end
      ref_mem[6] = 16'h005A; smem[6] = 16'h005A;
      repeat (2) @(negedge PCLK);
      #1 check_all_zero("reset");
      @(posedge PCLK); #1;
      PRESETn = 1'b1;

      force_waits = 0;
      issue(1'b0, 1'b1, 3'd2, 16'h0ABC, lat);
      chk("write_latency", 32'(lat), 32'(4));
      issue(1'b1, 1'b0, 3'd6, 16'h0000, lat);
      chk("read_latency", 32'(lat), 32'(4));
      chk("read_rdata", 32'(bus.rdata_o), 32'(16'h005A));

      do_reset("rst2");
      fork
         repeat (2) issue(1'b0, 1'b1, AW'($urandom_range(0, 7)), DW'($urandom), lat);
         repeat (2) issue(1'b1, 1'b0, AW'($urandom_range(0, 7)), DW'($urandom), lat_r);
      join

      force_waits = 3;
      issue(1'b0, 1'b1, 3'd5, 16'hC0DE, lat);
      chk("wait_latency", 32'(lat), 32'(7));

      force_waits = 5;
      fork
         issue(1'b0, 1'b1, 3'd3, 16'h1234, lat);
         begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
               @(negedge PCLK);
               if (bus.PSELx_o && bus.PENABLE_o) got = 1'b1;
            end
            chk("abort_reach_access", 32'(got), 32'(1));
            #2 PRESETn = 1'b0;
            force_waits = 0;
            #1 check_all_zero("abort");
            @(negedge PCLK);
            @(negedge PCLK);
            @(posedge PCLK); #1;
            PRESETn = 1'b1;
         end
      join

      force_waits = -1;
      fork
         agent(1'b0, 40);
         agent(1'b1, 40);
      join

`ifdef APB_TIMEOUT_EN
      force_waits = 1000;
      issue(1'b1, 1'b0, 3'd4, 16'h0000, lat);
      chk("timeout_latency", 32'(lat), 32'(7));
      force_waits = 0;
`endif

      repeat (4) @(negedge PCLK);
      chk("queues_drained", 32'(q0.size() + q1.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- Two-requester APB master that shares the register-file APB slave (command/transmit/id/data TX registers, RX and status read-back) between the lift-control sequencer (requester 0) and the host/debug port (requester 1).
- Round-robin arbitration; generates APB SETUP/ACCESS phases; honours PREADY wait states.
- Returns read data with a one-cycle done pulse to the granted requester.

Parameters:
- ADDRESSWIDTH, 3, width of PADDR_o and reqN_addr_i
- DATAWIDTH, 16, width of PWDATA_o, PRDATA_i, reqN_wdata_i, rdata_o
- TIMEOUT, 16, max ACCESS cycles with PREADY low (used only with APB_TIMEOUT_EN); range 2..255

Ports:
- PCLK  in  1  clock, rising edge
- PRESETn  in  1  asynchronous active-low reset
- req0_i / req1_i  in  1  transfer request; held high with stable controls until own done
- req0_write_i / req1_write_i  in  1  1=write, 0=read
- req0_addr_i / req1_addr_i  in  ADDRESSWIDTH  register address
- req0_wdata_i / req1_wdata_i  in  DATAWIDTH  write data
- done0_o / done1_o  out  1  one-cycle completion pulse
- rdata_o  out  DATAWIDTH  read data; valid while doneN_o high for a read
- err_o  out  1  timeout flag, pulses with doneN_o (tied 0 without APB_TIMEOUT_EN)
- busy_o  out  1  high in SETUP/ACCESS/CAPTURE
- PSELx_o, PENABLE_o, PWRITE_o  out  1  APB controls
- PADDR_o  out  ADDRESSWIDTH  APB address
- PWDATA_o  out  DATAWIDTH  APB write data
- PRDATA_i  in  DATAWIDTH  APB read data; slave registers it, valid the cycle after the ACCESS completion edge
- PREADY_i  in  1  APB ready

Behaviour:
- Reset: all outputs 0; FSM=IDLE; last_grant=1, so requester 0 wins the first tie.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, CAPTURE.
- IDLE:
  - Eligible = reqN_i high and doneN_o not high this cycle.
  - If exactly one is eligible, grant it. If both, grant the one != last_grant.
  - On grant: latch write/addr/wdata into PWRITE_o/PADDR_o/PWDATA_o, update last_grant, PSELx_o<=1, go SETUP.
- SETUP: PENABLE_o<=1; go ACCESS. Exactly one cycle.
- ACCESS:
  - PREADY_i=0: hold all APB outputs and stay.
  - PREADY_i=1: PSELx_o<=0, PENABLE_o<=0; go CAPTURE.
- CAPTURE:
  - rdata_o<=PRDATA_i for reads; rdata_o unchanged for writes.
  - doneN_o<=1 for the granted requester; go IDLE.
- doneN_o is high during the first IDLE cycle after CAPTURE, then clears.
- Requester handshake: the requester drops reqN_i on the edge where it samples doneN_o. The served requester is ineligible during its done cycle, so there is no double transfer.
- Latency with zero wait states, reqN_i high in IDLE cycle t:
  - SETUP at t+1, ACCESS at t+2, CAPTURE at t+3, doneN_o at t+4.
  - Each wait state adds one cycle.
- Back-to-back: the other requester can be granted in the done cycle, giving a 4-cycle transfer period.
- reqN_i or its controls changing after grant: ignored; the latched transfer completes.
- PADDR_o/PWDATA_o/PWRITE_o keep their last value in IDLE.
- Reset asserted mid-transfer: immediate return to reset state; no done pulse for the aborted transfer.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY_i=0.
  - When it reaches TIMEOUT: drop PSELx_o/PENABLE_o and go to CAPTURE with a timeout flag set.
  - CAPTURE then pulses doneN_o with err_o=1; rdata_o is unchanged.
- APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; err_o tied 0.

Test Plan:
- Write, no wait states: req0 write addr 2 data 0x0ABC, PREADY=1.
  - Expect PSEL/PENABLE 0/0→1/0→1/1→0/0, PADDR=2, PWDATA=0x0ABC.
  - Expect done0_o at t+4, err_o=0.
- Read: req1 read addr 6, slave PRDATA=0x005A the cycle after ACCESS.
  - Expect rdata_o=0x005A with done1_o at t+4; done0_o stays 0.
- Simultaneous requests: req0 and req1 raised together from reset, both held.
  - Expect order req0, req1, req0, req1, one done pulse per transfer, 4-cycle spacing.
- Wait states: PREADY low for 3 ACCESS cycles.
  - Expect APB outputs stable throughout, done at t+7.
- Reset mid-transfer: PRESETn low during ACCESS.
  - Expect all outputs 0 immediately, no done pulse.
  - After release, a pending req0 starts a fresh SETUP.
- APB_TIMEOUT_EN, TIMEOUT=4, PREADY held 0:
  - Expect PSELx_o drop after 4 ACCESS cycles, then doneN_o with err_o=1 and rdata_o unchanged.
